// File: rtl/display_frame_scheduler.sv
// Display frame scheduler: IDLE/RUN/PAUSE sequencer that advances a 3-bit
// frame index from a prescaled enable and can request periodic inversion.
// Optional feature macro: FRAME_SCHED_STEP_EN enables single-frame stepping
// while paused; without it the step input is accepted but has no effect.
//
// state | meaning
// IDLE  | stopped, frame index parked at 0
// RUN   | prescaler free-running, one advance per prescale_max+1 enabled clks
// PAUSE | frame index frozen, optional manual step
// (11)  | illegal encoding, returns to IDLE on the next enabled clk
module display_frame_scheduler #(
   parameter int PRESCALE_W   = 16,
   parameter int INVERT_EVERY = 8
) (
   input  logic                  clk,
   input  logic                  sync_rst,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  step,
   input  logic                  mode_bounce,
   input  logic [PRESCALE_W-1:0] prescale_max,
   output logic [2:0]            count_lower,
   output logic                  invert_led_state,
   output logic                  frame_tick,
   output logic [1:0]            sched_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_BAD   = 2'b11
   } state_t;

   localparam int INV_W = (INVERT_EVERY > 1) ? $clog2(INVERT_EVERY) : 1;
   localparam logic [INV_W-1:0] INV_LAST =
      (INVERT_EVERY > 0) ? INV_W'(INVERT_EVERY - 1) : '0;

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [2:0]            count_q, count_d;
   logic                  dir_q, dir_d;       // 0 = up, 1 = down
   logic [INV_W-1:0]      inv_cnt_q, inv_cnt_d;
   logic                  frame_tick_q, invert_q;
   logic                  advance, inv_pulse, step_adv;

`ifdef FRAME_SCHED_STEP_EN
   assign step_adv = step && !stop;
`else
   logic unused_step;
   assign unused_step = step;
   assign step_adv    = 1'b0;
`endif

   // Next-state, prescaler, frame index and invert counter
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      count_d   = count_q;
      dir_d     = dir_q;
      inv_cnt_d = inv_cnt_q;
      advance   = 1'b0;
      inv_pulse = 1'b0;
      if (clk_en) begin
         case (state_q)
            S_IDLE: begin
               if (start && !stop) state_d = S_RUN;
            end
            S_RUN: begin
               if (stop) state_d = S_PAUSE;
               if (presc_q == prescale_max) begin
                  advance = 1'b1;
                  presc_d = '0;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            S_PAUSE: begin
               if (stop)       state_d = S_IDLE;
               else if (start) state_d = S_RUN;
               advance = step_adv;
            end
            default: state_d = S_IDLE;
         endcase

         // Leaving bounce mode always resumes counting upward
         if (!mode_bounce) dir_d = 1'b0;

         if (advance) begin
            if (!mode_bounce) begin
               count_d = count_q + 3'd1;
            end else if (!dir_q) begin
               if (count_q == 3'd7) begin
                  count_d = 3'd6;
                  dir_d   = 1'b1;
               end else begin
                  count_d = count_q + 3'd1;
               end
            end else begin
               if (count_q == 3'd0) begin
                  count_d = 3'd1;
                  dir_d   = 1'b0;
               end else begin
                  count_d = count_q - 3'd1;
               end
            end
            if (INVERT_EVERY > 0) begin
               if (inv_cnt_q == INV_LAST) begin
                  inv_pulse = 1'b1;
                  inv_cnt_d = '0;
               end else begin
                  inv_cnt_d = inv_cnt_q + 1'b1;
               end
            end
         end

         if (state_q != S_RUN && state_d == S_RUN) presc_d = '0;
         if (state_q == S_PAUSE && state_d == S_IDLE) begin
            count_d   = 3'd0;
            dir_d     = 1'b0;
            inv_cnt_d = '0;
         end
      end
   end

   // State and datapath registers; pulses are registered from the advance
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         count_q      <= 3'd0;
         dir_q        <= 1'b0;
         inv_cnt_q    <= '0;
         frame_tick_q <= 1'b0;
         invert_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         count_q      <= count_d;
         dir_q        <= dir_d;
         inv_cnt_q    <= inv_cnt_d;
         frame_tick_q <= advance;
         invert_q     <= inv_pulse;
      end
   end

   assign count_lower      = count_q;
   assign frame_tick       = frame_tick_q;
   assign invert_led_state = invert_q;
   assign sched_state      = state_q;

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Bench for display_frame_scheduler: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_display_frame_scheduler;

   localparam int PW = 16;
   localparam int IE = 8;

   logic          clk = 1'b0;
   logic          sync_rst = 1'b1, clk_en = 1'b0, start = 1'b0, stop = 1'b0;
   logic          step = 1'b0, mode_bounce = 1'b0;
   logic [PW-1:0] prescale_max = '0;
   logic [2:0]    count_lower;
   logic          invert_led_state, frame_tick;
   logic [1:0]    sched_state;

   int errors = 0;
   int checks = 0;

   // model: phase p walks 0..13 in bounce (index = p<=7 ? p : 14-p),
   // and equals the index itself when counting upward
   int m_st = 0, m_p = 0, m_pres = 0, m_ic = 0, m_ft = 0, m_inv = 0;

   display_frame_scheduler #(.PRESCALE_W(PW), .INVERT_EVERY(IE)) dut (
      .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .start(start),
      .stop(stop), .step(step), .mode_bounce(mode_bounce),
      .prescale_max(prescale_max), .count_lower(count_lower),
      .invert_led_state(invert_led_state), .frame_tick(frame_tick),
      .sched_state(sched_state));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int idx_of(input int p);
      return (p <= 7) ? p : 14 - p;
   endfunction

   task automatic model_step();
      int adv;
      if (sync_rst) begin
         m_st = 0; m_p = 0; m_pres = 0; m_ic = 0; m_ft = 0; m_inv = 0;
      end else if (!clk_en) begin
         m_ft = 0; m_inv = 0;
      end else begin
         adv = 0;
         if (m_st == 1) begin
            if (m_pres == int'(prescale_max)) begin
               adv = 1; m_pres = 0;
            end else begin
               m_pres++;
            end
         end
`ifdef FRAME_SCHED_STEP_EN
         if (m_st == 2 && step && !stop) adv = 1;
`endif
         if (!mode_bounce) m_p = idx_of(m_p);
         m_inv = 0;
         if (adv != 0) begin
            m_p = mode_bounce ? (m_p + 1) % 14 : (m_p + 1) % 8;
            if (IE > 0) begin
               m_ic++;
               if (m_ic == IE) begin
                  m_inv = 1; m_ic = 0;
               end
            end
         end
         m_ft = adv;
         case (m_st)
            0: if (start && !stop) begin m_st = 1; m_pres = 0; end
            1: if (stop) m_st = 2;
            default: begin
               if (stop) begin
                  m_st = 0; m_p = 0; m_ic = 0;
               end else if (start) begin
                  m_st = 1; m_pres = 0;
               end
            end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("state", int'(sched_state), m_st);
      check("count", int'(count_lower), idx_of(m_p));
      check("frame_tick", int'(frame_tick), m_ft);
      check("invert", int'(invert_led_state), m_inv);
   endtask

   task automatic drive(input logic r, input logic e, input logic sa,
                        input logic so, input logic sp);
      sync_rst = r; clk_en = e; start = sa; stop = so; step = sp;
   endtask

   int seq[$];
   int exp_bounce[15] = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};

   initial begin
      // reset
      drive(1, 0, 1, 0, 0);
      tick(); tick();
      check("rst_state", int'(sched_state), 0);
      check("rst_count", int'(count_lower), 0);

      // prescale_max=3: advances on enabled cycles 4, 8, 12 after start
      prescale_max = 3; mode_bounce = 0;
      drive(0, 1, 1, 0, 0); tick();
      drive(0, 1, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k % 4 == 0) begin
            check("ps3_count", int'(count_lower), k / 4);
            check("ps3_tick", int'(frame_tick), 1);
         end else begin
            check("ps3_notick", int'(frame_tick), 0);
         end
      end

      // RUN->PAUSE, steps, PAUSE->IDLE
      drive(0, 1, 0, 1, 0); tick();
      check("pause_state", int'(sched_state), 2);
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 0, 1); tick();
         drive(0, 1, 0, 0, 0); tick();
      end
`ifdef FRAME_SCHED_STEP_EN
      check("step_count", int'(count_lower), 6);
`else
      check("step_count", int'(count_lower), 3);
`endif
      drive(0, 1, 0, 1, 0); tick();
      check("idle_state", int'(sched_state), 0);
      check("idle_count", int'(count_lower), 0);

      // start and stop together
      drive(0, 1, 1, 1, 0); tick();
      check("both_idle", int'(sched_state), 0);
      drive(0, 1, 1, 0, 0); tick();
      drive(0, 1, 1, 1, 0); tick();
      check("both_run", int'(sched_state), 2);
      drive(0, 1, 0, 1, 0); tick();

      // bounce, prescale_max=0
      prescale_max = 0; mode_bounce = 1;
      drive(0, 1, 1, 0, 0); tick();
      drive(0, 1, 0, 0, 0);
      for (int k = 0; k < 15; k++) begin
         tick();
         seq.push_back(int'(count_lower));
      end
      foreach (exp_bounce[i]) check("bounce_seq", seq[i], exp_bounce[i]);

      // invert pulses on advances 8 and 16
      mode_bounce = 0;
      drive(1, 1, 0, 0, 0); tick();
      drive(0, 1, 1, 0, 0); tick();
      drive(0, 1, 0, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("inv_pulse", int'(invert_led_state), (k % 8 == 0) ? 1 : 0);
         check("inv_tick", int'(frame_tick), 1);
      end

      // reset mid-RUN at count 5
      drive(1, 1, 0, 0, 0); tick();
      drive(0, 1, 1, 0, 0); tick();
      drive(0, 1, 0, 0, 0);
      for (int k = 0; k < 5; k++) tick();
      check("pre_rst_count", int'(count_lower), 5);
      drive(1, 1, 1, 0, 0); tick();
      check("midrst_state", int'(sched_state), 0);
      check("midrst_count", int'(count_lower), 0);
      check("midrst_tick", int'(frame_tick), 0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         sync_rst = ($urandom_range(0, 127) == 0);
         clk_en   = ($urandom_range(0, 3) != 0);
         start    = ($urandom_range(0, 7) == 0);
         stop     = ($urandom_range(0, 11) == 0);
         step     = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 63) == 0) mode_bounce = ~mode_bounce;
         if ($urandom_range(0, 99) == 0) prescale_max = PW'($urandom_range(0, 3));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
